// File: rtl/alu_share_arb_if.sv
// Bundle of requester, ALU and response signals around the shared ALU arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding core, which holds the requesters, the ALU and the response
// consumers.
interface alu_share_arb_if #(
  parameter int XLEN = 32
) ();

  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_in1;
  logic [XLEN-1:0] req0_in2;
  logic [3:0]      req0_funct;

  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_in1;
  logic [XLEN-1:0] req1_in2;
  logic [3:0]      req1_funct;

  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [3:0]      alu_funct;
  logic [XLEN-1:0] alu_out;

  logic            rsp0_valid;
  logic            rsp1_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp0_ready;
  logic            rsp1_ready;

  modport slave (
    input  req0_valid, req0_in1, req0_in2, req0_funct,
    output req0_ready,
    input  req1_valid, req1_in1, req1_in2, req1_funct,
    output req1_ready,
    output alu_in1, alu_in2, alu_funct,
    input  alu_out,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_in1, req0_in2, req0_funct,
    input  req0_ready,
    output req1_valid, req1_in1, req1_in2, req1_funct,
    input  req1_ready,
    input  alu_in1, alu_in2, alu_funct,
    output alu_out,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready
  );

endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter for the shared ALU. It serves two requesters and keeps
// a one-entry response buffer. The buffer can drain and refill in the same
// cycle, so one operation per cycle is sustained without backpressure.
module alu_share_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_share_arb_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            rsp_id;
  logic            rsp_id_next;
  logic            last_grant;
  logic            last_grant_next;
  logic [XLEN-1:0] rsp_data;
  logic [XLEN-1:0] rsp_data_next;

  logic            grant_any;
  logic            grant_id;
  logic            owner_ready;
  logic            issue_ok;
  logic            handshake;

  // Combinational grant. On a tie, the requester that did not win last time wins.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Issue is allowed when the buffer is empty or is being drained this cycle.
  always_comb begin
    owner_ready    = rsp_id ? bus.rsp1_ready : bus.rsp0_ready;
    issue_ok       = (state == EMPTY) || owner_ready;
    bus.req0_ready = issue_ok & grant_any & ~grant_id;
    bus.req1_ready = issue_ok & grant_any & grant_id;
    handshake      = bus.req0_ready | bus.req1_ready;
  end

  // The ALU operand mux follows the grant even while stalled, so the operands
  // stay steady and do not swap between requesters.
  always_comb begin
    bus.alu_in1   = '0;
    bus.alu_in2   = '0;
    bus.alu_funct = 4'b0000;
    if (grant_any) begin
      if (grant_id) begin
        bus.alu_in1   = bus.req1_in1;
        bus.alu_in2   = bus.req1_in2;
        bus.alu_funct = bus.req1_funct;
      end else begin
        bus.alu_in1   = bus.req0_in1;
        bus.alu_in2   = bus.req0_in2;
        bus.alu_funct = bus.req0_funct;
      end
    end
  end

  // Next-state logic for the response buffer: refill on handshake, otherwise drain or hold.
  always_comb begin
    state_next      = state;
    rsp_id_next     = rsp_id;
    last_grant_next = last_grant;
    rsp_data_next   = rsp_data;
    if (handshake) begin
      state_next      = FULL;
      rsp_id_next     = grant_id;
      last_grant_next = grant_id;
      rsp_data_next   = bus.alu_out;
    end else if ((state == FULL) && owner_ready) begin
      state_next = EMPTY;
    end
  end

  // State registers. Reset discards any buffered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      rsp_data   <= '0;
    end else begin
      state      <= state_next;
      rsp_id     <= rsp_id_next;
      last_grant <= last_grant_next;
      rsp_data   <= rsp_data_next;
    end
  end

  assign bus.rsp0_valid = (state == FULL) & ~rsp_id;
  assign bus.rsp1_valid = (state == FULL) & rsp_id;
  assign bus.rsp_data   = rsp_data;

endmodule
